// File: rtl/uart_cmd_rx.sv
// UART 8N1 receiver feeding a 5-byte command frame parser: 55 CMD DH DL SUM.
// rx_data_valid, cmd_valid and frame_err are single-cycle pulses with no back-pressure; a consumer must take the value on the pulse.
module uart_cmd_rx #(
    parameter int CLK_FRE      = 50,
    parameter int BAUD_RATE    = 115200,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_pin,
    output logic [7:0]  rx_data,
    output logic        rx_data_valid,
    output logic [7:0]  cmd,
    output logic [15:0] cmd_data,
    output logic        cmd_valid,
    output logic        frame_err,
    output logic [1:0]  o_dbg_rx_state,
    output logic [2:0]  o_dbg_parse_state
);

    localparam int CYCLE   = CLK_FRE * 1000000 / BAUD_RATE;
    localparam int TIMEOUT = TIMEOUT_BITS * CYCLE;
    localparam int CW      = $clog2(CYCLE + 1);
    localparam int TW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CYCLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CYCLE - 1);
    localparam logic [TW-1:0] TO_M1   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_t;
    typedef enum logic [2:0] {P_HEAD, P_CMD, P_DH, P_DL, P_SUM} parse_state_t;

    logic            r_rx_s1, r_rx_s2, r_rx_d;
    rx_state_t       r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic [7:0]      r_rx_data;
    logic            r_rx_valid;
    logic            r_stop_err;

    parse_state_t    r_pstate;
    logic [7:0]      r_cmd_tmp, r_dh, r_dl;
    logic [7:0]      r_cmd;
    logic [15:0]     r_cmd_data;
    logic            r_cmd_valid;
    logic            r_frame_err;
    logic [TW-1:0]   r_to_cnt;

    logic            w_fall;
    logic [7:0]      w_sum;

    assign w_fall = r_rx_d & ~r_rx_s2;
    assign w_sum  = r_cmd_tmp + r_dh + r_dl;

    // Synchronizer resets to idle-high so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_rx_s1 <= rx_pin;
            r_rx_s2 <= r_rx_s1;
            r_rx_d  <= r_rx_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_stop_err <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_stop_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (r_cnt == HALF_M1) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_state   <= r_rx_s2 ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt   <= '0;
                        r_shift <= {r_rx_s2, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    // Back to idle at the stop centre so a start bit right after the stop bit is caught.
                    if (r_cnt == FULL_M1) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        if (r_rx_s2) begin
                            r_rx_data  <= r_shift;
                            r_rx_valid <= 1'b1;
                        end else begin
                            r_stop_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A stop-bit error wins over a same-cycle timeout; both collapse into one frame_err pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pstate    <= P_HEAD;
            r_cmd_tmp   <= '0;
            r_dh        <= '0;
            r_dl        <= '0;
            r_cmd       <= '0;
            r_cmd_data  <= '0;
            r_cmd_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_to_cnt    <= '0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_frame_err <= 1'b0;
            if (r_stop_err) begin
                r_pstate    <= P_HEAD;
                r_frame_err <= 1'b1;
                r_to_cnt    <= '0;
            end else if (r_rx_valid) begin
                r_to_cnt <= '0;
                case (r_pstate)
                    P_HEAD: if (r_rx_data == 8'h55) r_pstate <= P_CMD;
                    P_CMD: begin
                        r_cmd_tmp <= r_rx_data;
                        r_pstate  <= P_DH;
                    end
                    P_DH: begin
                        r_dh     <= r_rx_data;
                        r_pstate <= P_DL;
                    end
                    P_DL: begin
                        r_dl     <= r_rx_data;
                        r_pstate <= P_SUM;
                    end
                    P_SUM: begin
                        r_pstate <= P_HEAD;
                        if (r_rx_data == w_sum) begin
                            r_cmd       <= r_cmd_tmp;
                            r_cmd_data  <= {r_dh, r_dl};
                            r_cmd_valid <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                    default: r_pstate <= P_HEAD;
                endcase
            end else if (r_pstate != P_HEAD) begin
                if (r_to_cnt == TO_M1) begin
                    r_pstate    <= P_HEAD;
                    r_frame_err <= 1'b1;
                    r_to_cnt    <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    assign rx_data           = r_rx_data;
    assign rx_data_valid     = r_rx_valid;
    assign cmd               = r_cmd;
    assign cmd_data          = r_cmd_data;
    assign cmd_valid         = r_cmd_valid;
    assign frame_err         = r_frame_err;
    assign o_dbg_rx_state    = r_state;
    assign o_dbg_parse_state = r_pstate;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: one instance at default rates, one fast instance for tables and random frames.
module tb_uart_cmd_rx;
    localparam int BT_A = 434;
    localparam int BT_B = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic rx_a = 1'b1;
    logic rx_b = 1'b1;

    logic [7:0]  rx_data_a, cmd_a, rx_data_b, cmd_b;
    logic [15:0] cmd_data_a, cmd_data_b;
    logic        rx_valid_a, cmd_valid_a, err_a, rx_valid_b, cmd_valid_b, err_b;
    logic [1:0]  dbg_rx_a, dbg_rx_b;
    logic [2:0]  dbg_ps_a, dbg_ps_b;

    always #10 clk = ~clk;

    uart_cmd_rx u_dut_a (
        .clk(clk), .rst_n(rst_n), .rx_pin(rx_a),
        .rx_data(rx_data_a), .rx_data_valid(rx_valid_a),
        .cmd(cmd_a), .cmd_data(cmd_data_a), .cmd_valid(cmd_valid_a),
        .frame_err(err_a), .o_dbg_rx_state(dbg_rx_a), .o_dbg_parse_state(dbg_ps_a)
    );

    uart_cmd_rx #(.CLK_FRE(50), .BAUD_RATE(2500000), .TIMEOUT_BITS(20)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rx_pin(rx_b),
        .rx_data(rx_data_b), .rx_data_valid(rx_valid_b),
        .cmd(cmd_b), .cmd_data(cmd_data_b), .cmd_valid(cmd_valid_b),
        .frame_err(err_b), .o_dbg_rx_state(dbg_rx_b), .o_dbg_parse_state(dbg_ps_b)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference model for instance B: byte-level frame rules over a queue.
    logic [7:0]  exp_rx_q[$];
    logic [23:0] exp_cmd_q[$];
    int          m_frame[$];
    int          m_err = 0;
    logic [7:0]  m_cmd = 8'h00;
    logic [15:0] m_data = 16'h0000;

    task automatic model_byte(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok) begin
            m_err++;
            m_frame.delete();
        end else begin
            exp_rx_q.push_back(b);
            if (m_frame.size() != 0 || b == 8'h55) begin
                m_frame.push_back(int'(b));
                if (m_frame.size() == 5) begin
                    if ((m_frame[1] + m_frame[2] + m_frame[3]) % 256 == m_frame[4]) begin
                        m_cmd  = 8'(m_frame[1]);
                        m_data = {8'(m_frame[2]), 8'(m_frame[3])};
                        exp_cmd_q.push_back({m_cmd, m_data});
                    end else begin
                        m_err++;
                    end
                    m_frame.delete();
                end
            end
        end
    endtask

    task automatic model_gap();
        if (m_frame.size() != 0) begin
            m_err++;
            m_frame.delete();
        end
    endtask

    // Monitors, sampled on the falling edge.
    int n_rx_b = 0, n_cmd_b = 0, n_err_b = 0;
    logic prev_rxv_b = 1'b0, prev_cmdv_b = 1'b0, prev_err_b = 1'b0;
    always @(negedge clk) begin
        if (rx_valid_b) begin
            n_rx_b++;
            check("rx_b_width", prev_rxv_b, 0);
            check("rx_b_expected", exp_rx_q.size() != 0, 1);
            if (exp_rx_q.size() != 0) check("rx_b_data", rx_data_b, exp_rx_q.pop_front());
        end
        if (cmd_valid_b) begin
            n_cmd_b++;
            check("cmd_b_width", prev_cmdv_b, 0);
            check("cmd_b_expected", exp_cmd_q.size() != 0, 1);
            if (exp_cmd_q.size() != 0) check("cmd_b_value", {cmd_b, cmd_data_b}, exp_cmd_q.pop_front());
        end
        if (err_b) begin
            n_err_b++;
            check("err_b_width", prev_err_b, 0);
            check("err_b_excl", cmd_valid_b, 0);
        end
        prev_rxv_b  = rx_valid_b;
        prev_cmdv_b = cmd_valid_b;
        prev_err_b  = err_b;
    end

    int n_rx_a = 0, n_cmd_a = 0, n_err_a = 0;
    logic [7:0] got_a_q[$];
    always @(negedge clk) begin
        if (rx_valid_a) begin
            n_rx_a++;
            got_a_q.push_back(rx_data_a);
        end
        if (cmd_valid_a) n_cmd_a++;
        if (err_a) n_err_a++;
    end

    // Drivers
    task automatic hold(input bit sel_a, input logic v, input int n);
        if (sel_a) rx_a = v;
        else rx_b = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input bit sel_a, input logic [7:0] b, input bit stop_ok, input int gap_bits);
        int bt;
        bt = sel_a ? BT_A : BT_B;
        if (!sel_a) begin
            model_byte(b, stop_ok);
            if (gap_bits >= 15) model_gap();
        end
        hold(sel_a, 1'b0, bt);
        for (int i = 0; i < 8; i++) hold(sel_a, b[i], bt);
        hold(sel_a, stop_ok, bt);
        if (gap_bits > 0) hold(sel_a, 1'b1, gap_bits * bt);
    endtask

    task automatic send_frame_b(input logic [39:0] f, input int gap_bits);
        for (int i = 0; i < 5; i++) send_byte(1'b0, f[39-8*i -: 8], 1'b1, gap_bits);
    endtask

    task automatic checkpoint();
        model_gap();
        repeat (25 * BT_B) @(posedge clk);
        #1;
        check("ckpt_err_count", n_err_b, m_err);
        check("ckpt_rx_left", exp_rx_q.size(), 0);
        check("ckpt_cmd_left", exp_cmd_q.size(), 0);
        check("ckpt_cmd", cmd_b, m_cmd);
        check("ckpt_cmd_data", cmd_data_b, m_data);
    endtask

    typedef struct {
        logic [39:0] frame;
        logic [7:0]  exp_cmd;
        logic [15:0] exp_data;
        int          exp_cmds;
        int          exp_errs;
    } vec_t;

    initial begin
        vec_t vecs[7];
        logic [7:0] want_a[5];
        int base_cmd, base_err, base_rx;
        logic [7:0] fb[5];
        logic [7:0] c, dh, dl, g;
        int kind, bad_idx, long_idx, gap;
        bit stop_ok;

        vecs[0] = '{40'h55_01_12_34_47, 8'h01, 16'h1234, 1, 0};
        vecs[1] = '{40'h55_01_12_34_48, 8'h01, 16'h1234, 0, 1};
        vecs[2] = '{40'h55_02_00_FF_01, 8'h02, 16'h00FF, 1, 0};
        vecs[3] = '{40'h55_03_00_01_04, 8'h03, 16'h0001, 1, 0};
        vecs[4] = '{40'h55_FF_FF_FF_FD, 8'hFF, 16'hFFFF, 1, 0};
        vecs[5] = '{40'h55_80_80_00_00, 8'h80, 16'h8000, 1, 0};
        vecs[6] = '{40'h55_00_00_00_01, 8'h80, 16'h8000, 0, 1};
        want_a = '{8'h55, 8'h01, 8'h12, 8'h34, 8'h47};

        // Reset
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_data_a", rx_data_a, 0);
        check("rst_cmd_a", {cmd_a, cmd_data_a}, 0);
        check("rst_pulses_a", {rx_valid_a, cmd_valid_a, err_a}, 0);
        check("rst_dbg_a", {dbg_rx_a, dbg_ps_a}, 0);
        check("rst_outs_b", {rx_data_b, cmd_b, cmd_data_b, rx_valid_b, cmd_valid_b, err_b}, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Short low glitch on the default-rate instance
        hold(1'b1, 1'b0, 100);
        hold(1'b1, 1'b1, 600);
        check("glitch_rx_count", n_rx_a, 0);
        check("glitch_err_count", n_err_a, 0);
        check("glitch_state_idle", dbg_rx_a, 0);

        // Reference frame at 115200 baud, default clock
        for (int i = 0; i < 5; i++) send_byte(1'b1, want_a[i], 1'b1, 0);
        hold(1'b1, 1'b1, 2 * BT_A);
        check("a_rx_count", n_rx_a, 5);
        for (int i = 0; i < 5; i++) begin
            if (i < got_a_q.size()) check("a_rx_byte", got_a_q[i], want_a[i]);
        end
        check("a_cmd_count", n_cmd_a, 1);
        check("a_err_count", n_err_a, 0);
        check("a_cmd", cmd_a, 8'h01);
        check("a_cmd_data", cmd_data_a, 16'h1234);

        // Table of frames on the fast instance
        hold(1'b0, 1'b1, 2 * BT_B);
        for (int i = 0; i < 7; i++) begin
            base_cmd = n_cmd_b;
            base_err = n_err_b;
            send_frame_b(vecs[i].frame, 1);
            hold(1'b0, 1'b1, 5);
            check("vec_cmd_pulses", n_cmd_b - base_cmd, vecs[i].exp_cmds);
            check("vec_err_pulses", n_err_b - base_err, vecs[i].exp_errs);
            check("vec_cmd", cmd_b, vecs[i].exp_cmd);
            check("vec_cmd_data", cmd_data_b, vecs[i].exp_data);
        end
        checkpoint();

        // Bad stop bit, then a good frame
        base_err = n_err_b;
        base_rx = n_rx_b;
        send_byte(1'b0, 8'hA5, 1'b0, 2);
        hold(1'b0, 1'b1, 5);
        check("stop_err_pulse", n_err_b - base_err, 1);
        check("stop_err_no_rx", n_rx_b - base_rx, 0);
        send_frame_b(40'h55_02_00_FF_01, 0);
        hold(1'b0, 1'b1, BT_B);
        check("after_stop_cmd", cmd_b, 8'h02);
        check("after_stop_data", cmd_data_b, 16'h00FF);
        checkpoint();

        // Inter-byte timeout, then a good frame
        base_err = n_err_b;
        base_cmd = n_cmd_b;
        send_byte(1'b0, 8'h55, 1'b1, 0);
        send_byte(1'b0, 8'h01, 1'b1, 20);
        check("timeout_err_pulse", n_err_b - base_err, 1);
        send_frame_b(40'h55_03_00_01_04, 0);
        hold(1'b0, 1'b1, BT_B);
        check("after_to_cmd_pulses", n_cmd_b - base_cmd, 1);
        check("after_to_cmd", cmd_b, 8'h03);
        check("after_to_data", cmd_data_b, 16'h0001);
        checkpoint();

        // Reset asserted during bit 4 of the DH byte
        send_byte(1'b0, 8'h55, 1'b1, 0);
        send_byte(1'b0, 8'h01, 1'b1, 0);
        send_byte(1'b0, 8'h12, 1'b1, 0);
        dh = 8'h34;
        hold(1'b0, 1'b0, BT_B);
        for (int i = 0; i < 4; i++) hold(1'b0, dh[i], BT_B);
        rx_b = dh[4];
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_rx_data", rx_data_b, 0);
        check("midrst_cmd", cmd_b, 0);
        check("midrst_cmd_data", cmd_data_b, 0);
        check("midrst_pulses", {rx_valid_b, cmd_valid_b, err_b}, 0);
        check("midrst_dbg", {dbg_rx_b, dbg_ps_b}, 0);
        m_frame.delete();
        m_cmd = 8'h00;
        m_data = 16'h0000;
        rx_b = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        hold(1'b0, 1'b1, 3 * BT_B);
        base_cmd = n_cmd_b;
        send_frame_b(40'h55_05_10_20_35, 0);
        hold(1'b0, 1'b1, BT_B);
        check("postrst_cmd_pulses", n_cmd_b - base_cmd, 1);
        check("postrst_cmd", cmd_b, 8'h05);
        check("postrst_data", cmd_data_b, 16'h1020);
        checkpoint();

        // Randomized frames against the model
        for (int it = 0; it < 12; it++) begin
            kind = $urandom_range(0, 4);
            c  = 8'($urandom_range(0, 255));
            dh = 8'($urandom_range(0, 255));
            dl = 8'($urandom_range(0, 255));
            fb[0] = 8'h55;
            fb[1] = c;
            fb[2] = dh;
            fb[3] = dl;
            fb[4] = 8'((int'(c) + int'(dh) + int'(dl)) % 256);
            if (kind == 1) fb[4] = fb[4] ^ 8'(1 << $urandom_range(0, 7));
            bad_idx = $urandom_range(0, 4);
            long_idx = $urandom_range(0, 3);
            if (kind == 3) begin
                g = 8'($urandom_range(0, 255));
                if (g == 8'h55) g = 8'h54;
                send_byte(1'b0, g, 1'b1, $urandom_range(0, 3));
            end
            for (int k = 0; k < 5; k++) begin
                stop_ok = !(kind == 2 && k == bad_idx);
                if (kind == 4 && k == long_idx) gap = 22;
                else if (stop_ok) gap = $urandom_range(0, 3);
                else gap = $urandom_range(1, 3);
                send_byte(1'b0, fb[k], stop_ok, gap);
            end
            if (it % 4 == 3) checkpoint();
        end

        $display("Result: errors=%0d of %0d checks", n_fail, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_cmd_rx.md
UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001 SHALL have parameter CLK_FRE, default 50, system clock frequency in MHz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, serial bit rate in bits/s.
REQ-003 SHALL have parameter TIMEOUT_BITS, default 20, maximum inter-byte gap inside a frame, in bit-times.
REQ-004 SHALL have port clk, input, 1, system clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port rx_pin, input, 1, asynchronous UART line, idle high, 8N1.
REQ-007 SHALL have port rx_data, output, 8, last received byte.
REQ-008 SHALL have port rx_data_valid, output, 1, one-cycle pulse when rx_data updates.
REQ-009 SHALL have port cmd, output, 8, command byte of last good frame.
REQ-010 SHALL have port cmd_data, output, 16, payload of last good frame, {DH,DL}.
REQ-011 SHALL have port cmd_valid, output, 1, one-cycle pulse when cmd/cmd_data update.
REQ-012 SHALL have port frame_err, output, 1, one-cycle pulse on any error (REQ-021..023).

Function
REQ-013 SHALL define CYCLE = CLK_FRE*1000000/BAUD_RATE clocks per bit (434 at defaults).
REQ-014 SHALL pass rx_pin through a 2-FF synchronizer (reset value 1); all decisions use the synchronized signal.
REQ-015 SHALL implement byte FSM S_IDLE -> S_START -> S_DATA -> S_STOP -> S_IDLE.
REQ-016 S_IDLE: a 1->0 transition of the synchronized line SHALL enter S_START with bit counter cleared.
REQ-017 S_START: at count CYCLE/2-1 the line SHALL be sampled; 0 -> S_DATA, 1 -> S_IDLE (glitch rejected, no pulse).
REQ-018 S_DATA: 8 bits SHALL be sampled LSB first, each CYCLE clocks after the previous sample (bit centres).
REQ-019 S_STOP: line sampled CYCLE clocks after bit 7; 1 -> rx_data loaded and rx_data_valid pulsed the following cycle; FSM returns to S_IDLE in the same cycle as the stop sample, so a back-to-back start edge is detected.
REQ-020 SHALL implement frame parser P_HEAD -> P_CMD -> P_DH -> P_DL -> P_SUM -> P_HEAD, advancing one state per valid byte; in P_HEAD only 0x55 advances, other bytes are discarded silently.
REQ-021 Stop-bit sample 0 SHALL discard the byte, pulse frame_err, and force the parser to P_HEAD.
REQ-022 In P_SUM, byte != (CMD+DH+DL) mod 256 SHALL pulse frame_err, leave cmd/cmd_data unchanged, return to P_HEAD.
REQ-023 Parser outside P_HEAD with no rx_data_valid for TIMEOUT_BITS*CYCLE clocks SHALL pulse frame_err and return to P_HEAD; counter clears on each rx_data_valid.
REQ-024 Matching checksum SHALL load cmd and cmd_data and pulse cmd_valid exactly one cycle after the checksum byte's rx_data_valid.
REQ-025 rx_data_valid, cmd_valid and frame_err SHALL never be high longer than one cycle; cmd_valid and frame_err SHALL never be high together.
REQ-026 Timeout and a stop-bit error in the same cycle SHALL produce a single frame_err pulse.

Reset
REQ-027 rst_n low SHALL immediately set rx_data=0, rx_data_valid=0, cmd=0, cmd_data=0, cmd_valid=0, frame_err=0, byte FSM to S_IDLE, parser to P_HEAD, all counters 0.
REQ-028 Reset released mid-byte or mid-frame SHALL discard partial data; the next 1->0 edge after release starts a fresh byte.

Verification
REQ-029 Frame 55 01 12 34 47 at 115200, defaults -> five rx_data_valid pulses, then cmd_valid once, cmd=0x01, cmd_data=0x1234, no frame_err.
REQ-030 Frame 55 01 12 34 48 -> frame_err once, no cmd_valid, cmd/cmd_data keep prior values.
REQ-031 rx_pin low for 100 clocks then high -> no rx_data_valid, no frame_err, FSM in S_IDLE.
REQ-032 Byte 0xA5 with stop bit 0 -> no rx_data_valid, frame_err once; following frame 55 02 00 FF 01 -> cmd=0x02, cmd_data=0x00FF.
REQ-033 Bytes 55 01 then idle 20*434 clocks -> frame_err once; then 55 03 00 01 04 -> cmd_valid, cmd=0x03, cmd_data=0x0001.
REQ-034 rst_n pulsed low during bit 4 of DH byte -> all outputs 0 immediately; subsequent good frame decoded correctly.
